sha1_pad: RTL and testbench

SHA1_PAD -- requirements
Module: sha1_pad

---
 rtl/sha1_pad.sv | 160 ++++++++++++++++
 tb/tb_sha1_pad.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/sha1_pad.sv
// rtl/sha1_pad.sv - SHA-1 message padder: byte stream in, padded big-endian 32-bit words out
module sha1_pad (
  input  logic        wb_clk_i,
  input  logic        reset_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  in_data,
  input  logic        in_keep,
  input  logic        in_last,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic [3:0]  out_idx,
  output logic        out_block_last,
  output logic        out_msg_last,
  output logic        overflow
);

  typedef enum logic [2:0] {S_DATA, S_PAD, S_ZERO, S_LEN_HI, S_LEN_LO} state_t;

  state_t      state_q;
  logic [31:0] acc_q;
  logic [1:0]  acc_cnt_q;
  logic [31:0] bytecnt_q;
  logic        overflow_q;
  logic [3:0]  idx_q;
  logic        extra_q;
  logic        out_valid_q;
  logic [31:0] out_data_q;
  logic [3:0]  out_idx_q;
  logic        out_msg_last_q;

  logic        load_ok;
  logic        accept;
  logic        fill;
  logic [2:0]  n_c;
  logic [31:0] word_c;
  logic        emit_en;
  logic [31:0] emit_word;
  logic        emit_last;

  assign load_ok  = !out_valid_q || out_ready;
  // A last beat always produces a word, so it needs room in the output register.
  assign in_ready = reset_n && (state_q == S_DATA) &&
                    (load_ok || (acc_cnt_q != 2'd3 && !in_last));
  assign accept   = in_valid && in_ready;
  assign n_c      = {1'b0, acc_cnt_q} + {2'b00, in_keep};
  assign fill     = accept && (n_c == 3'd4 || in_last);

  always_comb begin
    word_c = acc_q;
    if (in_keep) begin
      case (acc_cnt_q)
        2'd0:    word_c[31:24] = in_data;
        2'd1:    word_c[23:16] = in_data;
        2'd2:    word_c[15:8]  = in_data;
        default: word_c[7:0]   = in_data;
      endcase
    end
    if (in_last) begin
      case (n_c)
        3'd0:    word_c[31:24] = 8'h80;
        3'd1:    word_c[23:16] = 8'h80;
        3'd2:    word_c[15:8]  = 8'h80;
        3'd3:    word_c[7:0]   = 8'h80;
        default: ;
      endcase
    end
  end

  always_comb begin
    emit_en   = 1'b0;
    emit_word = 32'h0;
    emit_last = 1'b0;
    case (state_q)
      S_DATA:   begin emit_en = fill;    emit_word = word_c;                       end
      S_PAD:    begin emit_en = load_ok; emit_word = 32'h8000_0000;                end
      S_ZERO:   begin emit_en = load_ok; emit_word = 32'h0;                        end
      S_LEN_HI: begin emit_en = load_ok; emit_word = {29'b0, bytecnt_q[31:29]};    end
      S_LEN_LO: begin emit_en = load_ok; emit_word = {bytecnt_q[28:0], 3'b000};
                      emit_last = 1'b1;                                            end
      default:  ;
    endcase
  end

  always_ff @(posedge wb_clk_i or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= S_DATA;
      acc_q          <= 32'h0;
      acc_cnt_q      <= 2'd0;
      bytecnt_q      <= 32'h0;
      overflow_q     <= 1'b0;
      idx_q          <= 4'd0;
      extra_q        <= 1'b0;
      out_valid_q    <= 1'b0;
      out_data_q     <= 32'h0;
      out_idx_q      <= 4'd0;
      out_msg_last_q <= 1'b0;
    end else begin
      if (out_valid_q && out_ready) out_valid_q <= 1'b0;
      if (emit_en) begin
        out_valid_q    <= 1'b1;
        out_data_q     <= emit_word;
        out_idx_q      <= idx_q;
        out_msg_last_q <= emit_last;
        idx_q          <= idx_q + 4'd1;
      end
      case (state_q)
        S_DATA: if (accept) begin
          if (in_keep) begin
            if (&bytecnt_q) overflow_q <= 1'b1;
            else            bytecnt_q  <= bytecnt_q + 32'd1;
          end
          if (fill) begin
            acc_q     <= 32'h0;
            acc_cnt_q <= 2'd0;
            if (in_last) begin
              if (n_c == 3'd4) begin
                state_q <= S_PAD;
              end else begin
                state_q <= (idx_q == 4'd13) ? S_LEN_HI : S_ZERO;
                extra_q <= (idx_q == 4'd14);
              end
            end
          end else begin
            acc_q     <= word_c;
            acc_cnt_q <= n_c[1:0];
          end
        end
        S_PAD: if (load_ok) begin
          state_q <= (idx_q == 4'd13) ? S_LEN_HI : S_ZERO;
          extra_q <= (idx_q == 4'd14);
        end
        // extra_q marks a marker too late for the length: finish this block first.
        S_ZERO: if (load_ok) begin
          if (extra_q) begin
            if (idx_q == 4'd15) extra_q <= 1'b0;
          end else if (idx_q == 4'd13) begin
            state_q <= S_LEN_HI;
          end
        end
        S_LEN_HI: if (load_ok) state_q <= S_LEN_LO;
        S_LEN_LO: if (load_ok) begin
          state_q   <= S_DATA;
          bytecnt_q <= 32'h0;
          idx_q     <= 4'd0;
        end
        default: state_q <= S_DATA;
      endcase
    end
  end

  assign out_valid      = out_valid_q;
  assign out_data       = out_data_q;
  assign out_idx        = out_idx_q;
  assign out_block_last = (out_idx_q == 4'd15);
  assign out_msg_last   = out_msg_last_q;
  assign overflow       = overflow_q;

endmodule

// File: tb/tb_sha1_pad.sv
// tb/tb_sha1_pad.sv - directed bench for sha1_pad with reference padding model
module tb_sha1_pad;

  logic        wb_clk_i = 1'b0;
  logic        reset_n  = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  in_data  = 8'h0;
  logic        in_keep  = 1'b0;
  logic        in_last  = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_data;
  logic [3:0]  out_idx;
  logic        out_block_last;
  logic        out_msg_last;
  logic        overflow;

  int n_cmp = 0;
  int n_bad = 0;

  bit          bp_mode = 1'b0;
  logic [7:0]  msg_q[$];
  logic [31:0] got_w[$];
  logic [3:0]  got_i[$];
  bit          got_l[$];
  bit          got_b[$];
  logic [31:0] exp_w[$];
  bit          held_v = 1'b0;
  logic [36:0] held   = '0;

  sha1_pad dut (
    .wb_clk_i(wb_clk_i), .reset_n(reset_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_keep(in_keep), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_idx(out_idx), .out_block_last(out_block_last),
    .out_msg_last(out_msg_last), .overflow(overflow)
  );

  always #5 wb_clk_i = ~wb_clk_i;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Sink: random or constant out_ready, stall-stability check, word capture.
  initial forever begin
    @(negedge wb_clk_i);
    out_ready = bp_mode ? 1'($urandom_range(0, 1)) : 1'b1;
    #1;
    if (held_v) check("stall_hold", {27'b0, out_valid, out_idx, out_data}, {27'b0, held});
    held_v = out_valid && !out_ready;
    held   = {1'b1, out_idx, out_data};
    if (out_valid && out_ready) begin
      got_w.push_back(out_data);
      got_i.push_back(out_idx);
      got_l.push_back(out_msg_last);
      got_b.push_back(out_block_last);
    end
  end

  function automatic logic [31:0] getw(input int k);
    if (k < got_w.size()) return got_w[k];
    return 32'hDEAD_BEEF;
  endfunction

  function automatic void build_expected();
    logic [7:0]  p[$];
    logic [63:0] bitlen;
    p = msg_q;
    bitlen = 64'(msg_q.size()) * 64'd8;
    p.push_back(8'h80);
    while (p.size() % 64 != 56) p.push_back(8'h00);
    for (int j = 7; j >= 0; j--) p.push_back(bitlen[8*j +: 8]);
    exp_w = {};
    for (int k = 0; k < p.size() / 4; k++)
      exp_w.push_back({p[4*k], p[4*k+1], p[4*k+2], p[4*k+3]});
  endfunction

  task automatic beat(input logic [7:0] d, input logic k, input logic l);
    int tries;
    @(negedge wb_clk_i);
    in_valid = 1'b1; in_data = d; in_keep = k; in_last = l;
    #2;
    tries = 0;
    while (!in_ready && tries < 2000) begin
      @(negedge wb_clk_i);
      #2;
      tries++;
    end
    if (tries >= 2000) check("in_ready_timeout", 64'(tries), 64'd0);
    @(posedge wb_clk_i);
  endtask

  task automatic send(input int null_at, input bit with_last);
    int n;
    n = msg_q.size();
    if (n == 0) begin
      beat(8'h00, 1'b0, 1'b1);
    end else begin
      for (int i = 0; i < n; i++) begin
        if (i == null_at) beat(8'h00, 1'b0, 1'b0);
        beat(msg_q[i], 1'b1, with_last && (i == n - 1));
      end
    end
    @(negedge wb_clk_i);
    in_valid = 1'b0; in_keep = 1'b0; in_last = 1'b0;
  endtask

  task automatic run(input string name, input bit bp, input int null_at);
    bit done;
    int cyc;
    got_w = {}; got_i = {}; got_l = {}; got_b = {};
    bp_mode = bp;
    build_expected();
    send(null_at, 1'b1);
    done = 1'b0;
    cyc  = 0;
    while (!done && cyc < 3000) begin
      @(posedge wb_clk_i);
      cyc++;
      done = (got_l.size() > 0) && got_l[got_l.size() - 1];
    end
    bp_mode = 1'b0;
    repeat (3) @(posedge wb_clk_i);
    check({name, "_done"}, 64'(done), 64'd1);
    check({name, "_nwords"}, 64'(got_w.size()), 64'(exp_w.size()));
    for (int k = 0; k < exp_w.size() && k < got_w.size(); k++) begin
      check($sformatf("%s_w%0d", name, k), 64'(got_w[k]), 64'(exp_w[k]));
      check($sformatf("%s_idx%0d", name, k), 64'(got_i[k]), 64'(k % 16));
      check($sformatf("%s_last%0d", name, k), 64'(got_l[k]), 64'(k == exp_w.size() - 1));
      check($sformatf("%s_blast%0d", name, k), 64'(got_b[k]), 64'(k % 16 == 15));
    end
  endtask

  task automatic check_reset_state(input string name);
    check({name, "_out_valid"}, 64'(out_valid), 64'd0);
    check({name, "_in_ready"}, 64'(in_ready), 64'd0);
    check({name, "_out_data"}, 64'(out_data), 64'd0);
    check({name, "_out_idx"}, 64'(out_idx), 64'd0);
    check({name, "_blast"}, 64'(out_block_last), 64'd0);
    check({name, "_mlast"}, 64'(out_msg_last), 64'd0);
    check({name, "_overflow"}, 64'(overflow), 64'd0);
  endtask

  task automatic fill_msg(input int n);
    msg_q = {};
    for (int i = 0; i < n; i++) msg_q.push_back(8'(i * 7 + 3));
  endtask

  initial begin
    #3;
    check_reset_state("rst");
    repeat (2) @(negedge wb_clk_i);
    reset_n = 1'b1;
    repeat (2) @(negedge wb_clk_i);

    msg_q = '{8'h61, 8'h62, 8'h63};
    run("abc", 1'b0, -1);
    check("abc_w0_hand", 64'(getw(0)), 64'h6162_6380);
    check("abc_w15_hand", 64'(getw(15)), 64'h0000_0018);

    msg_q = {};
    run("empty", 1'b0, -1);
    check("empty_w0_hand", 64'(getw(0)), 64'h8000_0000);
    check("empty_w15_hand", 64'(getw(15)), 64'h0);

    msg_q = '{8'h61, 8'h62, 8'h63};
    run("abc_null", 1'b0, 1);
    check("abc_null_w0_hand", 64'(getw(0)), 64'h6162_6380);

    fill_msg(55);
    run("len55", 1'b0, -1);
    check("len55_w13_marker", 64'(getw(13) & 32'hFF), 64'h80);
    check("len55_w14_hand", 64'(getw(14)), 64'h0);
    check("len55_w15_hand", 64'(getw(15)), 64'h1B8);

    fill_msg(56);
    run("len56", 1'b0, -1);
    check("len56_w14_hand", 64'(getw(14)), 64'h8000_0000);
    check("len56_w31_hand", 64'(getw(31)), 64'h1C0);

    fill_msg(64);
    run("len64", 1'b0, -1);
    check("len64_w16_hand", 64'(getw(16)), 64'h8000_0000);
    check("len64_w31_hand", 64'(getw(31)), 64'h200);

    msg_q = '{8'h61, 8'h62, 8'h63};
    run("abc_bp", 1'b1, -1);
    fill_msg(56);
    run("len56_bp", 1'b1, -1);
    check("len56_bp_w31_hand", 64'(getw(31)), 64'h1C0);

    fill_msg(20);
    bp_mode = 1'b0;
    send(-1, 1'b0);
    @(negedge wb_clk_i);
    reset_n = 1'b0;
    #1;
    check_reset_state("midrst");
    repeat (2) @(negedge wb_clk_i);
    reset_n = 1'b1;
    repeat (2) @(negedge wb_clk_i);
    msg_q = '{8'h61, 8'h62, 8'h63};
    run("abc_after_rst", 1'b0, -1);
    check("abc_after_rst_w0_hand", 64'(getw(0)), 64'h6162_6380);
    check("abc_after_rst_w15_hand", 64'(getw(15)), 64'h0000_0018);
    check("overflow_end", 64'(overflow), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got timeout expected finish");
    $fatal(1);
  end

endmodule
